yurut_cok_kanal: RTL and testbench
==================================

YURUT_COK_KANAL -- requirements
Module: yurut_cok_kanal

Interface
REQ-001 SHALL have parameter VERI_GEN, default 32, meaning result data width.
REQ-002 SHALL have parameter KANAL_SAYISI, default 4, meaning number of functional-unit channels (>=2).
REQ-003 SHALL have parameter KUYRUK_DERINLIK, default 4, meaning in-order result queue depth (power of 2, >=2).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports durdur_i in 1 (global pipeline freeze) and bosalt_i in 1 (flush).
REQ-007 SHALL have issue ports buy_gecerli_i in 1, buy_kanal_i in clog2(KANAL_SAYISI), buy_hedef_yazmaci_i in 5, buy_yazmaca_yaz_i in 1, buy_hazir_o out 1.
REQ-008 SHALL have channel ports kanal_baslat_o out KANAL_SAYISI (one-hot start), kanal_mesgul_i in KANAL_SAYISI, kanal_sonuc_gecerli_i in KANAL_SAYISI, kanal_sonuc_i in KANAL_SAYISI*VERI_GEN.
REQ-009 SHALL have writeback ports gy_gecerli_o out 1, gy_hedef_yazmaci_o out 5, gy_yazmaca_yaz_o out 1, gy_veri_o out VERI_GEN, gy_hazir_i in 1.
REQ-010 SHALL have status ports yurut_stall_o out 1, doluluk_o out clog2(KUYRUK_DERINLIK+1), hata_o out 1.

Function
REQ-011 buy_hazir_o SHALL equal !dolu && !kanal_mesgul_i[k] && !bekleyen[k] && !iptal[k] && !bosalt_i && !durdur_i, k=buy_kanal_i.
REQ-012 Issue accepted when buy_gecerli_i && buy_hazir_o; same cycle kanal_baslat_o[k]=1 (combinational, one cycle), else kanal_baslat_o=0.
REQ-013 On accept, entry {kanal, hedef, yazmaca_yaz, bitti=0} SHALL be written at tail, tail increments modulo KUYRUK_DERINLIK, bekleyen[k] set, slot index stored per channel.
REQ-014 At most one outstanding operation per channel.
REQ-015 kanal_sonuc_gecerli_i[k] with bekleyen[k]: data captured into channel's stored slot, bitti=1, bekleyen[k] cleared; independent of durdur_i.
REQ-016 gy_gecerli_o SHALL be registered-state driven: 1 iff queue non-empty and head bitti=1; gy_* fields from head entry.
REQ-017 Pop when gy_gecerli_o && gy_hazir_i && !durdur_i; head increments modulo depth; strictly program order.
REQ-018 Latency: issue cycle t, result cycle t+L (L>=1) -> gy_gecerli_o earliest cycle t+L+1 if entry is head.
REQ-019 Full (doluluk_o==KUYRUK_DERINLIK): buy_hazir_o=0 even if pop occurs same cycle.
REQ-020 Push and pop same cycle: doluluk_o unchanged.
REQ-021 yurut_stall_o SHALL equal buy_gecerli_i && !buy_hazir_o.
REQ-022 bosalt_i: next cycle queue empty, doluluk_o=0, gy_gecerli_o=0; for each k with bekleyen[k] set, iptal[k] set, bekleyen[k] cleared.
REQ-023 Result on channel k with iptal[k]: discarded, iptal[k] cleared.
REQ-024 Result arriving in same cycle as bosalt_i: discarded, iptal[k] not set.
REQ-025 Result on channel with neither bekleyen nor iptal: discarded, hata_o set sticky.
REQ-026 durdur_i blocks issue and pop only; captures and flush still act.

Reset
REQ-027 rst_i SHALL have priority over bosalt_i and durdur_i.
REQ-028 On reset: head/tail 0, doluluk_o=0, bekleyen=0, iptal=0, hata_o=0, all bitti=0.
REQ-029 During reset: buy_hazir_o=0, kanal_baslat_o=0, gy_gecerli_o=0, gy_* data 0, yurut_stall_o follows REQ-021.
REQ-030 Reset mid-operation discards all entries; channel results during or after reset for pre-reset issues are treated per REQ-025.

Structure
REQ-031 Package yurut_paket SHALL hold parameter defaults, entry struct typedef (kanal, hedef, yazmaca_yaz, bitti, veri), channel constants KANAL_AMB=0, KANAL_YZ=1, KANAL_KRIPTO=2, KANAL_BOLME=3.
REQ-032 One sub-module sonuc_kuyrugu SHALL implement the circular buffer with tail push, indexed data write, head pop, flush.

Verification
REQ-033 Issue ch0 hedef=5, ch2 hedef=7; ch2 result 0xAA cycle 3, ch0 result 0x55 cycle 6 -> writeback hedef5/0x55 then hedef7/0xAA, order preserved.
REQ-034 Four issues to distinct channels, gy_hazir_i=0 -> doluluk_o=4, fifth buy_gecerli_i gives yurut_stall_o=1, kanal_baslat_o=0.
REQ-035 Issue ch1, bosalt_i cycle 2, ch1 result 0x12 cycle 4 -> no writeback, iptal[1] clears, ch1 issue accepted cycle 5.
REQ-036 Result on ch3 with nothing pending -> hata_o=1 and remains 1 until rst_i.
REQ-037 Head ready, durdur_i=1 for 3 cycles with gy_hazir_i=1 -> no pop; pop on first cycle after durdur_i drops.
REQ-038 Three entries pending, rst_i pulsed 1 cycle -> next cycle doluluk_o=0, gy_gecerli_o=0, all outputs 0.

Source files
------------

// File: rtl/yurut_paket.sv
// rtl/yurut_paket.sv - shared defaults, channel ids and result-queue entry layout for yurut_cok_kanal
package yurut_paket;

    localparam int VARSAYILAN_VERI_GEN        = 32;
    localparam int VARSAYILAN_KANAL_SAYISI    = 4;
    localparam int VARSAYILAN_KUYRUK_DERINLIK = 4;
    localparam int VARSAYILAN_KANAL_GEN       = $clog2(VARSAYILAN_KANAL_SAYISI);
    localparam int HEDEF_GEN                  = 5;

    localparam int KANAL_AMB    = 0;
    localparam int KANAL_YZ     = 1;
    localparam int KANAL_KRIPTO = 2;
    localparam int KANAL_BOLME  = 3;

    // Entry layout at the default configuration.
    typedef struct packed {
        logic [VARSAYILAN_KANAL_GEN-1:0] kanal;
        logic [HEDEF_GEN-1:0]            hedef;
        logic                            yazmaca_yaz;
        logic                            bitti;
        logic [VARSAYILAN_VERI_GEN-1:0]  veri;
    } kuyruk_girdi_t;

endpackage

// File: rtl/sonuc_kuyrugu.sv
// rtl/sonuc_kuyrugu.sv - in-order result ring: tail push, per-slot result write, head pop, flush
module sonuc_kuyrugu
    import yurut_paket::*;
#(
    parameter int VERI_GEN   = VARSAYILAN_VERI_GEN,
    parameter int DERINLIK   = VARSAYILAN_KUYRUK_DERINLIK,
    parameter int YAZ_SAYISI = VARSAYILAN_KANAL_SAYISI,
    localparam int IW = $clog2(DERINLIK),
    localparam int SW = $clog2(DERINLIK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           bosalt_i,
    input  logic                           itme_i,
    input  logic [HEDEF_GEN-1:0]           itme_hedef_i,
    input  logic                           itme_yaz_i,
    input  logic                           cekme_i,
    input  logic [YAZ_SAYISI-1:0]          yaz_gecerli_i,
    input  logic [YAZ_SAYISI*IW-1:0]       yaz_indeks_i,
    input  logic [YAZ_SAYISI*VERI_GEN-1:0] yaz_veri_i,
    output logic [IW-1:0]                  kuyruk_ucu_o,
    output logic [SW-1:0]                  doluluk_o,
    output logic                           dolu_o,
    output logic                           bas_hazir_o,
    output logic [HEDEF_GEN-1:0]           bas_hedef_o,
    output logic                           bas_yaz_o,
    output logic [VERI_GEN-1:0]            bas_veri_o
);

    logic [HEDEF_GEN-1:0] r_hedef [DERINLIK];
    logic [VERI_GEN-1:0]  r_veri  [DERINLIK];
    logic [DERINLIK-1:0]  r_yaz;
    logic [DERINLIK-1:0]  r_bitti;
    logic [IW-1:0]        r_bas;
    logic [IW-1:0]        r_kuyruk;
    logic [SW-1:0]        r_sayac;

    // Power-of-two depth: pointers wrap naturally at IW bits.
    always_ff @(posedge clk_i) begin
        if (rst_i || bosalt_i) begin
            r_bas    <= '0;
            r_kuyruk <= '0;
            r_sayac  <= '0;
            r_bitti  <= '0;
        end else begin
            for (int i = 0; i < YAZ_SAYISI; i++) begin
                if (yaz_gecerli_i[i]) begin
                    r_veri[yaz_indeks_i[i*IW +: IW]]  <= yaz_veri_i[i*VERI_GEN +: VERI_GEN];
                    r_bitti[yaz_indeks_i[i*IW +: IW]] <= 1'b1;
                end
            end
            if (itme_i) begin
                r_hedef[r_kuyruk] <= itme_hedef_i;
                r_yaz[r_kuyruk]   <= itme_yaz_i;
                r_bitti[r_kuyruk] <= 1'b0;
                r_kuyruk          <= r_kuyruk + 1'b1;
            end
            if (cekme_i) begin
                r_bas <= r_bas + 1'b1;
            end
            case ({itme_i, cekme_i})
                2'b10:   r_sayac <= r_sayac + 1'b1;
                2'b01:   r_sayac <= r_sayac - 1'b1;
                default: r_sayac <= r_sayac;
            endcase
        end
    end

    assign kuyruk_ucu_o = r_kuyruk;
    assign doluluk_o    = r_sayac;
    assign dolu_o       = (r_sayac == SW'(DERINLIK));
    assign bas_hazir_o  = (r_sayac != '0) && r_bitti[r_bas];
    assign bas_hedef_o  = r_hedef[r_bas];
    assign bas_yaz_o    = r_yaz[r_bas];
    assign bas_veri_o   = r_veri[r_bas];

endmodule

// File: rtl/yurut_cok_kanal.sv
// rtl/yurut_cok_kanal.sv - multi-channel execute stage: one-hot issue, out-of-order capture, in-order writeback
module yurut_cok_kanal
    import yurut_paket::*;
#(
    parameter int VERI_GEN        = VARSAYILAN_VERI_GEN,
    parameter int KANAL_SAYISI    = VARSAYILAN_KANAL_SAYISI,
    parameter int KUYRUK_DERINLIK = VARSAYILAN_KUYRUK_DERINLIK,
    localparam int KW = $clog2(KANAL_SAYISI),
    localparam int IW = $clog2(KUYRUK_DERINLIK),
    localparam int SW = $clog2(KUYRUK_DERINLIK + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             durdur_i,
    input  logic                             bosalt_i,
    input  logic                             buy_gecerli_i,
    input  logic [KW-1:0]                    buy_kanal_i,
    input  logic [HEDEF_GEN-1:0]             buy_hedef_yazmaci_i,
    input  logic                             buy_yazmaca_yaz_i,
    output logic                             buy_hazir_o,
    output logic [KANAL_SAYISI-1:0]          kanal_baslat_o,
    input  logic [KANAL_SAYISI-1:0]          kanal_mesgul_i,
    input  logic [KANAL_SAYISI-1:0]          kanal_sonuc_gecerli_i,
    input  logic [KANAL_SAYISI*VERI_GEN-1:0] kanal_sonuc_i,
    output logic                             gy_gecerli_o,
    output logic [HEDEF_GEN-1:0]             gy_hedef_yazmaci_o,
    output logic                             gy_yazmaca_yaz_o,
    output logic [VERI_GEN-1:0]              gy_veri_o,
    input  logic                             gy_hazir_i,
    output logic                             yurut_stall_o,
    output logic [SW-1:0]                    doluluk_o,
    output logic                             hata_o
);

    logic [KANAL_SAYISI-1:0] r_bekleyen;
    logic [KANAL_SAYISI-1:0] r_iptal;
    logic [IW-1:0]           r_slot [KANAL_SAYISI];
    logic                    r_hata;

    logic                       w_kanal_var;
    logic [KANAL_SAYISI-1:0]    w_secili;
    logic                       w_dolu;
    logic                       w_kabul;
    logic                       w_cek;
    logic                       w_bas_hazir;
    logic [HEDEF_GEN-1:0]       w_bas_hedef;
    logic                       w_bas_yaz;
    logic [VERI_GEN-1:0]        w_bas_veri;
    logic [IW-1:0]              w_kuyruk_ucu;
    logic [KANAL_SAYISI-1:0]    w_yaz_gecerli;
    logic [KANAL_SAYISI*IW-1:0] w_yaz_indeks;

    assign w_kanal_var = (32'(buy_kanal_i) < KANAL_SAYISI);
    assign w_secili    = w_kanal_var ? (KANAL_SAYISI'(1) << buy_kanal_i) : '0;

    assign buy_hazir_o = !rst_i && w_kanal_var && !w_dolu && !bosalt_i && !durdur_i
                       && ((w_secili & (kanal_mesgul_i | r_bekleyen | r_iptal)) == '0);
    assign w_kabul        = buy_gecerli_i && buy_hazir_o;
    assign kanal_baslat_o = w_kabul ? w_secili : '0;
    assign yurut_stall_o  = buy_gecerli_i && !buy_hazir_o;

    assign gy_gecerli_o       = !rst_i && w_bas_hazir;
    assign gy_hedef_yazmaci_o = gy_gecerli_o ? w_bas_hedef : '0;
    assign gy_yazmaca_yaz_o   = gy_gecerli_o && w_bas_yaz;
    assign gy_veri_o          = gy_gecerli_o ? w_bas_veri : '0;
    assign w_cek              = gy_gecerli_o && gy_hazir_i && !durdur_i;
    assign hata_o             = r_hata;

    // A result landing in a flush cycle is dropped along with its queue slot.
    assign w_yaz_gecerli = kanal_sonuc_gecerli_i & r_bekleyen & {KANAL_SAYISI{!bosalt_i}};

    always_comb begin
        w_yaz_indeks = '0;
        for (int k = 0; k < KANAL_SAYISI; k++) begin
            w_yaz_indeks[k*IW +: IW] = r_slot[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bekleyen <= '0;
            r_iptal    <= '0;
            r_hata     <= 1'b0;
        end else begin
            for (int k = 0; k < KANAL_SAYISI; k++) begin
                if (kanal_sonuc_gecerli_i[k]) begin
                    if (r_bekleyen[k]) begin
                        r_bekleyen[k] <= 1'b0;
                    end else if (r_iptal[k]) begin
                        r_iptal[k] <= 1'b0;
                    end else begin
                        r_hata <= 1'b1;
                    end
                end else if (bosalt_i && r_bekleyen[k]) begin
                    r_bekleyen[k] <= 1'b0;
                    r_iptal[k]    <= 1'b1;
                end
            end
            if (w_kabul) begin
                r_bekleyen[buy_kanal_i] <= 1'b1;
                r_slot[buy_kanal_i]     <= w_kuyruk_ucu;
            end
        end
    end

    sonuc_kuyrugu #(
        .VERI_GEN   (VERI_GEN),
        .DERINLIK   (KUYRUK_DERINLIK),
        .YAZ_SAYISI (KANAL_SAYISI)
    ) u_kuyruk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bosalt_i      (bosalt_i),
        .itme_i        (w_kabul),
        .itme_hedef_i  (buy_hedef_yazmaci_i),
        .itme_yaz_i    (buy_yazmaca_yaz_i),
        .cekme_i       (w_cek),
        .yaz_gecerli_i (w_yaz_gecerli),
        .yaz_indeks_i  (w_yaz_indeks),
        .yaz_veri_i    (kanal_sonuc_i),
        .kuyruk_ucu_o  (w_kuyruk_ucu),
        .doluluk_o     (doluluk_o),
        .dolu_o        (w_dolu),
        .bas_hazir_o   (w_bas_hazir),
        .bas_hedef_o   (w_bas_hedef),
        .bas_yaz_o     (w_bas_yaz),
        .bas_veri_o    (w_bas_veri)
    );

endmodule

// File: tb/tb_yurut_cok_kanal.sv
// tb/tb_yurut_cok_kanal.sv - directed self-checking bench for yurut_cok_kanal
module tb_yurut_cok_kanal;
    import yurut_paket::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         durdur_i;
    logic         bosalt_i;
    logic         buy_gecerli_i;
    logic [1:0]   buy_kanal_i;
    logic [4:0]   buy_hedef_yazmaci_i;
    logic         buy_yazmaca_yaz_i;
    logic         buy_hazir_o;
    logic [3:0]   kanal_baslat_o;
    logic [3:0]   kanal_mesgul_i;
    logic [3:0]   kanal_sonuc_gecerli_i;
    logic [127:0] kanal_sonuc_i;
    logic         gy_gecerli_o;
    logic [4:0]   gy_hedef_yazmaci_o;
    logic         gy_yazmaca_yaz_o;
    logic [31:0]  gy_veri_o;
    logic         gy_hazir_i;
    logic         yurut_stall_o;
    logic [2:0]   doluluk_o;
    logic         hata_o;

    int n_assert = 0;
    int n_fail   = 0;
    kuyruk_girdi_t beklenen [2];

    always #5 clk_i = ~clk_i;

    yurut_cok_kanal #(
        .VERI_GEN        (32),
        .KANAL_SAYISI    (4),
        .KUYRUK_DERINLIK (4)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .durdur_i              (durdur_i),
        .bosalt_i              (bosalt_i),
        .buy_gecerli_i         (buy_gecerli_i),
        .buy_kanal_i           (buy_kanal_i),
        .buy_hedef_yazmaci_i   (buy_hedef_yazmaci_i),
        .buy_yazmaca_yaz_i     (buy_yazmaca_yaz_i),
        .buy_hazir_o           (buy_hazir_o),
        .kanal_baslat_o        (kanal_baslat_o),
        .kanal_mesgul_i        (kanal_mesgul_i),
        .kanal_sonuc_gecerli_i (kanal_sonuc_gecerli_i),
        .kanal_sonuc_i         (kanal_sonuc_i),
        .gy_gecerli_o          (gy_gecerli_o),
        .gy_hedef_yazmaci_o    (gy_hedef_yazmaci_o),
        .gy_yazmaca_yaz_o      (gy_yazmaca_yaz_o),
        .gy_veri_o             (gy_veri_o),
        .gy_hazir_i            (gy_hazir_i),
        .yurut_stall_o         (yurut_stall_o),
        .doluluk_o             (doluluk_o),
        .hata_o                (hata_o)
    );

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] gereken);
        n_assert++;
        assert (gozlenen === gereken) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", etiket, gozlenen, gereken);
        end
    endtask

    task automatic tik();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bosta();
        durdur_i              = 1'b0;
        bosalt_i              = 1'b0;
        buy_gecerli_i         = 1'b0;
        buy_kanal_i           = 2'd0;
        buy_hedef_yazmaci_i   = 5'd0;
        buy_yazmaca_yaz_i     = 1'b0;
        kanal_mesgul_i        = 4'b0;
        kanal_sonuc_gecerli_i = 4'b0;
        kanal_sonuc_i         = '0;
        gy_hazir_i            = 1'b0;
    endtask

    task automatic buy(input int k, input logic [4:0] h, input logic y);
        buy_gecerli_i       = 1'b1;
        buy_kanal_i         = 2'(k);
        buy_hedef_yazmaci_i = h;
        buy_yazmaca_yaz_i   = y;
    endtask

    task automatic sonuc(input int k, input logic [31:0] v);
        kanal_sonuc_gecerli_i[k]  = 1'b1;
        kanal_sonuc_i[k*32 +: 32] = v;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        beklenen[0] = '{kanal: 2'(KANAL_AMB),    hedef: 5'd5, yazmaca_yaz: 1'b1, bitti: 1'b1, veri: 32'h55};
        beklenen[1] = '{kanal: 2'(KANAL_KRIPTO), hedef: 5'd7, yazmaca_yaz: 1'b1, bitti: 1'b1, veri: 32'hAA};

        // Reset behaviour
        bosta();
        rst_i = 1'b1;
        buy(0, 5'd1, 1'b1);
        #1;
        kontrol("rst_hazir", buy_hazir_o, 0);
        kontrol("rst_stall", yurut_stall_o, 1);
        kontrol("rst_baslat", kanal_baslat_o, 0);
        tik(); tik();
        kontrol("rst_gy_gecerli", gy_gecerli_o, 0);
        kontrol("rst_gy_veri", gy_veri_o, 0);
        rst_i = 1'b0;
        bosta();
        tik();
        kontrol("ilk_doluluk", doluluk_o, 0);
        kontrol("ilk_hata", hata_o, 0);
        kontrol("ilk_hazir", buy_hazir_o, 1);

        // Out-of-order completion, in-order writeback
        buy(KANAL_AMB, 5'd5, 1'b1);
        #1;
        kontrol("t1_hazir", buy_hazir_o, 1);
        kontrol("t1_baslat0", kanal_baslat_o, 4'b0001);
        tik();
        buy(KANAL_KRIPTO, 5'd7, 1'b1);
        #1;
        kontrol("t1_baslat2", kanal_baslat_o, 4'b0100);
        tik();
        bosta();
        sonuc(KANAL_KRIPTO, 32'hAA);
        #1;
        kontrol("t1_doluluk2", doluluk_o, 2);
        tik();
        bosta();
        #1;
        kontrol("t1_bas_bekliyor", gy_gecerli_o, 0);
        tik();
        sonuc(KANAL_AMB, 32'h55);
        tik();
        bosta();
        gy_hazir_i = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            kontrol($sformatf("t1_gy_gecerli%0d", i), gy_gecerli_o, 1);
            kontrol($sformatf("t1_gy_hedef%0d", i), gy_hedef_yazmaci_o, beklenen[i].hedef);
            kontrol($sformatf("t1_gy_yaz%0d", i), gy_yazmaca_yaz_o, beklenen[i].yazmaca_yaz);
            kontrol($sformatf("t1_gy_veri%0d", i), gy_veri_o, beklenen[i].veri);
            tik();
        end
        kontrol("t1_bos_doluluk", doluluk_o, 0);
        kontrol("t1_bos_gecerli", gy_gecerli_o, 0);

        // Busy channel blocks issue
        bosta();
        kanal_mesgul_i = 4'b0010;
        buy(KANAL_YZ, 5'd1, 1'b0);
        #1;
        kontrol("mesgul_hazir", buy_hazir_o, 0);
        kontrol("mesgul_stall", yurut_stall_o, 1);
        kontrol("mesgul_baslat", kanal_baslat_o, 0);
        tik();

        // Fill the queue, then full-with-pop and push-with-pop
        for (int i = 0; i < 4; i++) begin
            bosta();
            buy(i, 5'(10 + i), 1'(i));
            #1;
            kontrol($sformatf("t2_baslat%0d", i), kanal_baslat_o, 4'b0001 << i);
            tik();
        end
        bosta();
        buy(KANAL_AMB, 5'd15, 1'b0);
        for (int i = 0; i < 4; i++) sonuc(i, 32'h100 + 32'(i));
        #1;
        kontrol("t2_doluluk4", doluluk_o, 4);
        kontrol("t2_dolu_stall", yurut_stall_o, 1);
        kontrol("t2_dolu_baslat", kanal_baslat_o, 0);
        tik();
        bosta();
        gy_hazir_i = 1'b1;
        buy(KANAL_YZ, 5'd20, 1'b1);
        #1;
        kontrol("t2_bas_hedef", gy_hedef_yazmaci_o, 10);
        kontrol("t2_bas_veri", gy_veri_o, 32'h100);
        kontrol("t2_bas_yaz", gy_yazmaca_yaz_o, 0);
        kontrol("t2_dolu_cekme_hazir", buy_hazir_o, 0);
        tik();
        kontrol("t2_cekme_doluluk", doluluk_o, 3);
        kontrol("t2_bas2_hedef", gy_hedef_yazmaci_o, 11);
        kontrol("t2_bas2_veri", gy_veri_o, 32'h101);
        kontrol("t2_itcek_baslat", kanal_baslat_o, 4'b0010);
        tik();
        kontrol("t2_itcek_doluluk", doluluk_o, 3);
        kontrol("t2_bas3_hedef", gy_hedef_yazmaci_o, 12);

        // Reset with three entries queued
        bosta();
        rst_i = 1'b1;
        #1;
        kontrol("t3_rst_gecerli", gy_gecerli_o, 0);
        kontrol("t3_rst_veri", gy_veri_o, 0);
        kontrol("t3_rst_hedef", gy_hedef_yazmaci_o, 0);
        tik();
        rst_i = 1'b0;
        #1;
        kontrol("t3_doluluk", doluluk_o, 0);
        kontrol("t3_gecerli", gy_gecerli_o, 0);
        kontrol("t3_veri", gy_veri_o, 0);
        kontrol("t3_hata", hata_o, 0);
        sonuc(KANAL_YZ, 32'hDEAD);
        tik();
        bosta();
        kontrol("t3_eski_sonuc_hata", hata_o, 1);
        kontrol("t3_eski_sonuc_doluluk", doluluk_o, 0);
        rst_i = 1'b1;
        tik();
        rst_i = 1'b0;
        kontrol("t3_hata_temiz", hata_o, 0);

        // Flush with an outstanding op: late result is discarded
        buy(KANAL_YZ, 5'd9, 1'b1);
        #1;
        kontrol("t4_baslat", kanal_baslat_o, 4'b0010);
        tik();
        bosta();
        bosalt_i = 1'b1;
        #1;
        kontrol("t4_bosalt_hazir", buy_hazir_o, 0);
        kontrol("t4_once_doluluk", doluluk_o, 1);
        tik();
        bosta();
        buy(KANAL_YZ, 5'd9, 1'b1);
        #1;
        kontrol("t4_sonra_doluluk", doluluk_o, 0);
        kontrol("t4_iptal_hazir", buy_hazir_o, 0);
        kontrol("t4_iptal_stall", yurut_stall_o, 1);
        tik();
        bosta();
        sonuc(KANAL_YZ, 32'h12);
        tik();
        bosta();
        buy(KANAL_YZ, 5'd3, 1'b1);
        #1;
        kontrol("t4_atilan_gecerli", gy_gecerli_o, 0);
        kontrol("t4_atilan_hata", hata_o, 0);
        kontrol("t4_yeniden_baslat", kanal_baslat_o, 4'b0010);
        tik();
        bosta();
        sonuc(KANAL_YZ, 32'h77);
        tik();

        // Freeze holds the ready head
        bosta();
        durdur_i   = 1'b1;
        gy_hazir_i = 1'b1;
        buy(KANAL_AMB, 5'd2, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #1;
            kontrol($sformatf("t5_gecerli%0d", j), gy_gecerli_o, 1);
            kontrol($sformatf("t5_veri%0d", j), gy_veri_o, 32'h77);
            kontrol($sformatf("t5_durdur_hazir%0d", j), buy_hazir_o, 0);
            tik();
            kontrol($sformatf("t5_doluluk%0d", j), doluluk_o, 1);
        end
        durdur_i      = 1'b0;
        buy_gecerli_i = 1'b0;
        tik();
        kontrol("t5_cekildi", doluluk_o, 0);
        kontrol("t5_cekildi_gecerli", gy_gecerli_o, 0);

        // Result in the same cycle as flush leaves no cancel mark
        bosta();
        buy(KANAL_KRIPTO, 5'd4, 1'b0);
        tik();
        bosta();
        bosalt_i = 1'b1;
        sonuc(KANAL_KRIPTO, 32'h99);
        tik();
        bosta();
        buy(KANAL_KRIPTO, 5'd6, 1'b1);
        #1;
        kontrol("t6_hazir", buy_hazir_o, 1);
        kontrol("t6_hata", hata_o, 0);
        kontrol("t6_doluluk", doluluk_o, 0);
        tik();
        bosta();
        sonuc(KANAL_KRIPTO, 32'h31);
        tik();
        bosta();
        gy_hazir_i = 1'b1;
        #1;
        kontrol("t6_gy_veri", gy_veri_o, 32'h31);
        kontrol("t6_gy_hedef", gy_hedef_yazmaci_o, 6);
        tik();
        kontrol("t6_bos", doluluk_o, 0);

        // Unexpected result sets a sticky error
        bosta();
        sonuc(KANAL_BOLME, 32'h1);
        tik();
        bosta();
        kontrol("t7_hata", hata_o, 1);
        tik(); tik(); tik();
        kontrol("t7_hata_kalici", hata_o, 1);
        rst_i = 1'b1;
        tik();
        rst_i = 1'b0;
        kontrol("t7_hata_rst", hata_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
